// File: rtl/note_tone_gen.sv
// Note-to-tone generator: latches a 6-bit note index on an accepted strobe and
// splits it into octave/semitone by repeated subtraction, then plays a square wave.
module note_tone_gen #(
    parameter int TABLE_SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        pulse,
    input  logic [5:0]  note,
    output logic        wave,
    output logic        playing,
    output logic [5:0]  cur_note,
    output logic [16:0] half_period
);

    // state    | meaning
    // IDLE     | silent, waiting for an accepted strobe (also rest note 63)
    // CONVERT  | dividing the latched note by 12, one subtraction per cycle
    // PLAY     | counting half periods and toggling wave
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_PLAY    = 2'd2
    } state_t;

    localparam logic [5:0] NOTE_REST = 6'd63;

    state_t      state_q, state_d;
    logic        wave_q, wave_d;
    logic [16:0] counter_q, counter_d;
    logic [16:0] half_period_q, half_period_d;
    logic [5:0]  cur_note_q, cur_note_d;
    logic [5:0]  rem_q, rem_d;
    logic [2:0]  oct_q, oct_d;

    logic        accept;
    logic [31:0] shift_amt;
    logic [16:0] shifted;
    logic [16:0] hp_clamped;

    // Octave-0 half periods (C2..B2) in 10 MHz clock cycles.
    function automatic logic [16:0] period_lut(input logic [3:0] semi);
        logic [16:0] val;
        case (semi)
            4'd0:    val = 17'd76446;
            4'd1:    val = 17'd72154;
            4'd2:    val = 17'd68105;
            4'd3:    val = 17'd64282;
            4'd4:    val = 17'd60675;
            4'd5:    val = 17'd57269;
            4'd6:    val = 17'd54055;
            4'd7:    val = 17'd51021;
            4'd8:    val = 17'd48157;
            4'd9:    val = 17'd45455;
            4'd10:   val = 17'd42903;
            4'd11:   val = 17'd40495;
            default: val = 17'd40495;
        endcase
        return val;
    endfunction

    always_comb begin
        shift_amt  = 32'(oct_q) + 32'(TABLE_SHIFT);
        shifted    = period_lut(rem_q[3:0]) >> shift_amt;
        hp_clamped = (shifted == 17'd0) ? 17'd1 : shifted;
    end

    // Strobes arriving mid-conversion are dropped, not queued.
    assign accept = pulse & en & (state_q != ST_CONVERT);

    always_comb begin
        state_d       = state_q;
        wave_d        = wave_q;
        counter_d     = counter_q;
        half_period_d = half_period_q;
        cur_note_d    = cur_note_q;
        rem_d         = rem_q;
        oct_d         = oct_q;

        if (!en) begin
            state_d   = ST_IDLE;
            wave_d    = 1'b0;
            counter_d = 17'd0;
        end else if (accept) begin
            cur_note_d = note;
            wave_d     = 1'b0;
            counter_d  = 17'd0;
            if (note == NOTE_REST) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_CONVERT;
                rem_d   = note;
                oct_d   = 3'd0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wave_d    = 1'b0;
                    counter_d = 17'd0;
                end
                ST_CONVERT: begin
                    wave_d    = 1'b0;
                    counter_d = 17'd0;
                    if (rem_q >= 6'd12) begin
                        rem_d = rem_q - 6'd12;
                        oct_d = oct_q + 3'd1;
                    end else begin
                        half_period_d = hp_clamped;
                        state_d       = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (counter_q == half_period_q - 17'd1) begin
                        counter_d = 17'd0;
                        wave_d    = ~wave_q;
                    end else begin
                        counter_d = counter_q + 17'd1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    wave_d    = 1'b0;
                    counter_d = 17'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wave_q        <= 1'b0;
            counter_q     <= 17'd0;
            half_period_q <= 17'd0;
            cur_note_q    <= 6'd0;
            rem_q         <= 6'd0;
            oct_q         <= 3'd0;
        end else begin
            state_q       <= state_d;
            wave_q        <= wave_d;
            counter_q     <= counter_d;
            half_period_q <= half_period_d;
            cur_note_q    <= cur_note_d;
            rem_q         <= rem_d;
            oct_q         <= oct_d;
        end
    end

    assign wave        = wave_q;
    assign playing     = (state_q == ST_PLAY);
    assign cur_note    = cur_note_q;
    assign half_period = half_period_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: three instances (shift 0, 4, 16) share one stimulus stream.
module tb_note_tone_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        pulse = 1'b0;
    logic [5:0]  note = 6'd0;
    logic        wave_v [3];
    logic        playing_v [3];
    logic [5:0]  cur_v [3];
    logic [16:0] hp_v [3];

    always #5 clk = ~clk;

    note_tone_gen #(.TABLE_SHIFT(0)) u_s0 (
        .clk(clk), .rst(rst), .en(en), .pulse(pulse), .note(note),
        .wave(wave_v[0]), .playing(playing_v[0]), .cur_note(cur_v[0]), .half_period(hp_v[0]));
    note_tone_gen #(.TABLE_SHIFT(4)) u_s4 (
        .clk(clk), .rst(rst), .en(en), .pulse(pulse), .note(note),
        .wave(wave_v[1]), .playing(playing_v[1]), .cur_note(cur_v[1]), .half_period(hp_v[1]));
    note_tone_gen #(.TABLE_SHIFT(16)) u_s16 (
        .clk(clk), .rst(rst), .en(en), .pulse(pulse), .note(note),
        .wave(wave_v[2]), .playing(playing_v[2]), .cur_note(cur_v[2]), .half_period(hp_v[2]));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [5:0] note;
        int         sel;
        int         exp_hp;
        int         exp_lat;
    } vec_t;

    vec_t vecs [9];
    vec_t sb_q [$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Strobe a note and return the number of edges until playing rises (-1 on timeout).
    task automatic play_note(input logic [5:0] n, input int sel, output int lat);
        @(negedge clk);
        note  = n;
        pulse = 1'b1;
        lat   = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) pulse = 1'b0;
            if (playing_v[sel]) begin
                lat = k;
                break;
            end
        end
    endtask

    // Count cycles until wave reaches level, bounded by budget.
    task automatic wait_wave(input int sel, input logic level, input int budget, output int cyc);
        cyc = 0;
        while (wave_v[sel] !== level && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int lat;
        int cyc;
        int bad_w, bad_p, bad_c, bad_h;
        vec_t e;

        vecs[0] = '{6'd0,  0, 76446, 2};
        vecs[1] = '{6'd62, 1, 133,   7};
        vecs[2] = '{6'd60, 2, 1,     7};
        vecs[3] = '{6'd0,  1, 4777,  2};
        vecs[4] = '{6'd12, 1, 2388,  3};
        vecs[5] = '{6'd23, 2, 1,     3};
        vecs[6] = '{6'd11, 1, 2530,  2};
        vecs[7] = '{6'd47, 1, 316,   5};
        vecs[8] = '{6'd33, 1, 710,   4};

        // reset release, enabled, no strobe
        en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bad_w = 0; bad_p = 0; bad_c = 0; bad_h = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wave_v[0] !== 1'b0) bad_w++;
            if (playing_v[0] !== 1'b0) bad_p++;
            if (cur_v[0] !== 6'd0) bad_c++;
            if (hp_v[0] !== 17'd0) bad_h++;
        end
        check("idle_wave_nonzero_cycles", bad_w, 0);
        check("idle_playing_nonzero_cycles", bad_p, 0);
        check("idle_cur_note_nonzero_cycles", bad_c, 0);
        check("idle_half_period_nonzero_cycles", bad_h, 0);

        // full-pitch note 33 on the unshifted instance
        play_note(6'd33, 0, lat);
        check("n33_latency", lat, 4);
        check("n33_half_period", hp_v[0], 11363);
        check("n33_cur_note", cur_v[0], 33);
        wait_wave(0, 1'b1, 30000, cyc);
        check("n33_first_rise", cyc, 11363);
        wait_wave(0, 1'b0, 30000, cyc);
        check("n33_fall", cyc, 11363);

        // table vectors through the scoreboard
        for (int i = 0; i < 9; i++) begin
            sb_q.push_back(vecs[i]);
            play_note(vecs[i].note, vecs[i].sel, lat);
            e = sb_q.pop_front();
            check($sformatf("vec%0d_latency", i), lat, e.exp_lat);
            check($sformatf("vec%0d_half_period", i), hp_v[e.sel], e.exp_hp);
            check($sformatf("vec%0d_cur_note", i), cur_v[e.sel], e.note);
            if (e.exp_hp < 1000) begin
                wait_wave(e.sel, 1'b1, 2000, cyc);
                check($sformatf("vec%0d_rise", i), cyc, e.exp_hp);
                wait_wave(e.sel, 1'b0, 2000, cyc);
                check($sformatf("vec%0d_fall", i), cyc, e.exp_hp);
            end
        end

        // rest note from PLAY
        play_note(6'd0, 0, lat);
        check("n0_latency", lat, 2);
        @(negedge clk);
        note  = 6'd63;
        pulse = 1'b1;
        @(negedge clk);
        pulse = 1'b0;
        check("rest_playing", playing_v[0], 0);
        check("rest_wave", wave_v[0], 0);
        check("rest_cur_note", cur_v[0], 63);
        repeat (3) @(negedge clk);
        check("rest_stays_idle", playing_v[0], 0);

        // strobe during CONVERT is dropped
        note  = 6'd62;
        pulse = 1'b1;
        @(negedge clk);
        note  = 6'd5;
        @(negedge clk);
        pulse = 1'b0;
        lat   = -1;
        for (int k = 2; k <= 20; k++) begin
            if (playing_v[1]) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check("drop_latency", lat, 7);
        check("drop_cur_note", cur_v[1], 62);
        check("drop_half_period", hp_v[1], 133);

        // en low in PLAY
        en = 1'b0;
        @(negedge clk);
        check("en_low_playing", playing_v[1], 0);
        check("en_low_wave", wave_v[1], 0);
        check("en_low_cur_note", cur_v[1], 62);
        check("en_low_half_period", hp_v[1], 133);
        en = 1'b1;
        repeat (3) @(negedge clk);
        check("en_back_idle", playing_v[1], 0);

        // simultaneous en fall and strobe
        play_note(6'd12, 1, lat);
        check("n12_latency", lat, 3);
        @(negedge clk);
        en    = 1'b0;
        pulse = 1'b1;
        note  = 6'd30;
        @(negedge clk);
        pulse = 1'b0;
        check("sim_playing", playing_v[1], 0);
        check("sim_cur_note", cur_v[1], 12);
        en = 1'b1;
        repeat (8) @(negedge clk);
        check("sim_no_pending", playing_v[1], 0);

        // async reset mid-CONVERT
        note  = 6'd40;
        pulse = 1'b1;
        @(negedge clk);
        pulse = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_wave", wave_v[0], 0);
        check("rst_playing", playing_v[0], 0);
        check("rst_cur_note", cur_v[0], 0);
        check("rst_half_period", hp_v[0], 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_playing", playing_v[0], 0);
        check("post_rst_cur_note", cur_v[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/note_tone_gen.md
Name: note_tone_gen

Overview:
- Downstream consumer of the note-sequencer RNG stage's 6-bit note index and its note-change strobe.
- On each accepted strobe, latches the note and converts it to octave and semitone using an iterative divide-by-12.
- Looks up a half-period count and drives a square-wave tone (wave) toward the mixer/PWM output stage.
- Note 63 is a rest.

Parameters:
TABLE_SHIFT, 0, extra right shift applied to every looked-up half-period (0 = real pitch at 10 MHz clk; >0 shortens periods for simulation)

Ports:
clk  input  1  system clock, 10 MHz nominal
rst  input  1  asynchronous, active-high reset; all state cleared while high
en  input  1  synth enable (same enable as the RNG stage)
pulse  input  1  single-cycle note-change strobe (same strobe that advances the RNG note)
note  input  6  note index from RNG stage: octave = note/12, semitone = note%12
wave  output  1  square-wave tone
playing  output  1  high while in PLAY state
cur_note  output  6  last accepted note
half_period  output  17  active half-period count in clk cycles

Behaviour:
- Reset values (async, while rst=1 and after release until an accepted pulse): state IDLE, wave=0, playing=0, cur_note=0, half_period=0, internal counter=0, rem=0, oct=0.
- Accepted strobe: pulse&en sampled high at a clk edge while state is IDLE or PLAY. Pulses in CONVERT are dropped.
- Accepted strobe behaviour:
  - cur_note<=note. wave<=0, counter<=0.
  - If note==63, next state is IDLE (rest).
  - Otherwise, next state is CONVERT with rem<=note, oct<=0.
- States:
  - IDLE: wave=0, playing=0, counter held 0.
  - CONVERT: each cycle, if rem>=12 then rem<=rem-12 and oct<=oct+1. Else half_period<=TABLE[rem]>>(oct+TABLE_SHIFT) and state<=PLAY. wave=0, playing=0.
  - PLAY: playing=1. Counter increments each cycle. When counter==half_period-1: counter<=0 and wave toggles. First toggle (0->1) occurs half_period cycles after entering PLAY. Full tone period = 2*half_period cycles.
- Latency: playing rises oct+2 clk edges after the accepting edge (note 0 -> 2 edges; note 62 -> 7 edges).
- TABLE, 17-bit, octave 0 = C2..B2 at 10 MHz, indexed by semitone 0..11: 76446, 72154, 68105, 64282, 60675, 57269, 54055, 51021, 48157, 45455, 42903, 40495.
- If a shifted half_period evaluates to 0, use 1 (wave toggles every cycle).
- en low: at the next edge (in any state), go to IDLE with wave=0, counter=0. Outputs cur_note and half_period are held. en low also blocks pulse.
- pulse in PLAY: restarts from the accepting edge. Wave drops to 0 and the new CONVERT begins; there is no glitch-free phase continuation.
- Simultaneous en falling and pulse: the strobe is not accepted; go to IDLE.
- rst asserted mid-CONVERT or mid-PLAY: immediate return to reset values. No strobe is pending after release.
- pulse held high for several cycles: each cycle in IDLE/PLAY counts as a new strobe. The upstream stage guarantees single-cycle strobes.

Test Plan:
1. Reset release with en=1, no pulse -> wave=0, playing=0, cur_note=0, half_period=0 for 100 cycles.
2. TABLE_SHIFT=0, pulse with note=33 -> CONVERT for 3 cycles, playing rises 4 edges after strobe, half_period=11363, wave high after 11363 PLAY cycles, full period 22726.
3. TABLE_SHIFT=4, pulse with note=62 -> playing rises 7 edges after strobe, half_period=68105>>9=133, wave toggles every 133 cycles.
4. PLAY on note 0, then pulse with note=63 -> next cycle IDLE, wave=0, playing=0, cur_note=63.
5. Mid-PLAY: pulse during CONVERT is ignored (cur_note unchanged). Drop en -> IDLE next cycle. Assert rst mid-CONVERT -> all outputs 0 immediately.
6. TABLE_SHIFT=16, note=60 -> computed 0 clamps to 1, half_period=1, wave toggles every cycle.
